sram_axi_bridge: RTL
====================

SRAM_AXI_BRIDGE -- requirements
Module: sram_axi_bridge

Interface
REQ-001 Parameters SHALL be none; address and data widths SHALL be fixed at 32; AXI IDs SHALL be 4 bits.
REQ-002 clk  input  1  clock; all logic SHALL be on the rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 inst_req  input  1  instruction read request.
REQ-005 inst_addr  input  32  instruction word address.
REQ-006 inst_addr_ok  output  1  instruction request accepted this cycle.
REQ-007 inst_data_ok  output  1  instruction read data valid.
REQ-008 data_req  input  1  data request.
REQ-009 data_wr  input  1  1 = write, 0 = read.
REQ-010 data_wstrb  input  4  write byte strobes.
REQ-011 data_addr  input  32  data word address.
REQ-012 data_wdata  input  32  write data.
REQ-013 data_addr_ok  output  1  data request accepted this cycle.
REQ-014 data_data_ok  output  1  read data valid, or write complete.
REQ-015 cpu_rdata  output  32  read data, shared by both ports and qualified by the respective data_ok.
REQ-016 arid  output  4  read ID: 0 = instruction, 1 = data.
REQ-017 araddr  output  32  read address.
REQ-018 arvalid  output  1  read address valid.
REQ-019 arready  input  1  read address ready.
REQ-020 rid  input  4  read response ID.
REQ-021 rdata  input  32  read data.
REQ-022 rvalid  input  1  read data valid.
REQ-023 rready  output  1  read data ready.
REQ-024 awaddr  output  32  write address.
REQ-025 awvalid/awready  output/input  1/1  write address handshake.
REQ-026 wdata/wstrb  output  32/4  write data and strobes.
REQ-027 wvalid/wready  output/input  1/1  write data handshake.
REQ-028 bvalid/bready  input/output  1/1  write response handshake.

Function
REQ-029 The read FSM SHALL have states R_IDLE, R_AR and R_R, and SHALL allow one outstanding read.
- R_IDLE: accept a request (addr_ok=1 combinational), latch addr and ID, go to R_AR.
- R_AR: hold arvalid=1; on arready go to R_R.
- R_R: rready=1; on rvalid go to R_IDLE.
REQ-030 If a data read and an instruction read are both requested in R_IDLE, the data read SHALL win and inst_addr_ok SHALL be 0 that cycle.
REQ-031 The write FSM SHALL have states W_IDLE, W_REQ and W_B.
- W_IDLE: accept data_req&data_wr and latch addr, wdata and wstrb.
- W_REQ: assert awvalid and wvalid, each dropping independently after its own handshake; leave W_REQ once both handshakes are done.
- W_B: bready=1; on bvalid, pulse data_data_ok for 1 cycle and return to W_IDLE.
REQ-032 The data port SHALL accept a new request only when no data transaction is outstanding in either FSM, which keeps data responses in order.
REQ-033 An instruction read SHALL be able to proceed concurrently with an outstanding data write.
REQ-034 inst_data_ok and data_data_ok (read) SHALL be asserted in R_R when rvalid is high and rid is 0 or 1 respectively; cpu_rdata SHALL equal rdata.
REQ-035 A read data_ok and a write data_ok SHALL never coincide; REQ-032 guarantees this.
REQ-036 Fixed AXI fields SHALL be tied off outside this block: len=0, size=2, burst=INCR, awid=1.

Reset
REQ-037 On reset, both FSMs SHALL return to IDLE and all valids, readies and ok outputs SHALL be 0, including mid-transaction; outstanding AXI transfers SHALL be abandoned.

Configuration
REQ-038 With BRIDGE_RDATA_REG_EN defined, cpu_rdata and the read data_ok signals SHALL be registered: +1 cycle latency, and R_R SHALL exit one cycle after the R handshake. Without it, they SHALL be combinational as in REQ-034.

Structure
REQ-039 Package bridge_pkg SHALL hold the read/write state encodings, INST_ID=4'd0 and DATA_ID=4'd1; the write FSM SHALL be the single sub-module wr_channel.

Verification
REQ-040 Instruction read 0x1C000000, with arready after 1 cycle and rvalid (rid=0, rdata=0x02800C0C) after 2 cycles -> inst_addr_ok in cycle 0, arvalid held until arready, inst_data_ok=1 with cpu_rdata=0x02800C0C.
REQ-041 Same-cycle inst_req and data read of 0x1C008000 -> data accepted first with arid=1; instruction accepted in the cycle R_IDLE is re-entered.
REQ-042 Data write of 0xDEADBEEF to 0x1C008004 with wstrb=0xF, wready 3 cycles after awready -> exactly one aw and one w handshake, then data_data_ok once after bvalid.
REQ-043 Data write outstanding plus a new data read -> data_addr_ok=0 until the write's data_ok; an instruction read issued meanwhile completes.
REQ-044 reset asserted in R_AR -> next cycle arvalid=0 and FSM in R_IDLE; the first post-reset request is accepted normally.

Source files
------------

// File: rtl/bridge_pkg.sv
// Shared encodings for the SRAM-to-AXI bridge: read/write FSM states and the
// fixed AXI read IDs that tag which CPU port a read belongs to.
package bridge_pkg;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_AR   = 2'd1,
    R_R    = 2'd2
  } r_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_REQ  = 2'd1,
    W_B    = 2'd2
  } w_state_e;

  localparam logic [3:0] INST_ID = 4'd0;
  localparam logic [3:0] DATA_ID = 4'd1;

endpackage

// File: rtl/wr_channel.sv
// Write channel of the bridge: issues one AW/W pair per accepted data write and
// reports completion when the B response arrives.
module wr_channel
  import bridge_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  output logic        idle_o,
  output logic        done_o,
  output logic [31:0] awaddr_o,
  output logic        awvalid_o,
  input  logic        awready_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic        wvalid_o,
  input  logic        wready_i,
  input  logic        bvalid_i,
  output logic        bready_o
);

  w_state_e    state_q, state_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic [31:0] addr_q, data_q;
  logic [3:0]  strb_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= W_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (start_i && state_q == W_IDLE) begin
      addr_q <= addr_i;
      data_q <= wdata_i;
      strb_q <= wstrb_i;
    end
  end

  // AW and W complete independently; B is only awaited once both are done.
  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    awvalid_o = 1'b0;
    wvalid_o  = 1'b0;
    bready_o  = 1'b0;
    done_o    = 1'b0;
    unique case (state_q)
      W_IDLE: begin
        if (start_i) begin
          state_d   = W_REQ;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      W_REQ: begin
        awvalid_o = !aw_done_q;
        wvalid_o  = !w_done_q;
        if (!aw_done_q && awready_i) aw_done_d = 1'b1;
        if (!w_done_q && wready_i)   w_done_d  = 1'b1;
        if (aw_done_d && w_done_d)   state_d   = W_B;
      end
      W_B: begin
        bready_o = 1'b1;
        if (bvalid_i) begin
          done_o  = 1'b1;
          state_d = W_IDLE;
        end
      end
      default: state_d = W_IDLE;
    endcase
  end

  assign idle_o   = (state_q == W_IDLE);
  assign awaddr_o = addr_q;
  assign wdata_o  = data_q;
  assign wstrb_o  = strb_q;

endmodule

// File: rtl/sram_axi_bridge.sv
// SRAM-like instruction/data ports to a single-outstanding AXI master.
// Define BRIDGE_RDATA_REG_EN to register cpu_rdata and the read data_ok outputs.
module sram_axi_bridge
  import bridge_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] cpu_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  r_state_e    r_state_q, r_state_d;
  logic [3:0]  arid_q;
  logic [31:0] araddr_q;
  logic        wr_idle, wr_done;
  logic        rd_data_busy, data_rd_acc, data_wr_acc, inst_acc;
  logic        r_hs, r_exit, rd_data_ok;

  // Only one data transaction may be in flight across both channels.
  assign rd_data_busy = (r_state_q != R_IDLE) && (arid_q == DATA_ID);
  assign data_rd_acc  = (r_state_q == R_IDLE) && data_req && !data_wr && wr_idle;
  assign data_wr_acc  = data_req && data_wr && wr_idle && !rd_data_busy;
  assign inst_acc     = (r_state_q == R_IDLE) && inst_req && !data_rd_acc;

  assign data_addr_ok = data_rd_acc || data_wr_acc;
  assign inst_addr_ok = inst_acc;

  always_ff @(posedge clk) begin
    if (reset) r_state_q <= R_IDLE;
    else       r_state_q <= r_state_d;
  end

  always_ff @(posedge clk) begin
    if (data_rd_acc) begin
      arid_q   <= DATA_ID;
      araddr_q <= data_addr;
    end else if (inst_acc) begin
      arid_q   <= INST_ID;
      araddr_q <= inst_addr;
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    arvalid   = 1'b0;
    unique case (r_state_q)
      R_IDLE: if (data_rd_acc || inst_acc) r_state_d = R_AR;
      R_AR: begin
        arvalid = 1'b1;
        if (arready) r_state_d = R_R;
      end
      R_R:     if (r_exit) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  assign arid   = arid_q;
  assign araddr = araddr_q;

`ifdef BRIDGE_RDATA_REG_EN
  // R_R lingers one cycle after the handshake while the registered result is presented.
  logic        r_done_q, inst_ok_q, data_ok_q;
  logic [31:0] rdata_q;

  assign rready = (r_state_q == R_R) && !r_done_q;
  assign r_hs   = rready && rvalid;
  assign r_exit = r_done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_done_q  <= 1'b0;
      inst_ok_q <= 1'b0;
      data_ok_q <= 1'b0;
    end else begin
      r_done_q  <= r_hs;
      inst_ok_q <= r_hs && (rid == INST_ID);
      data_ok_q <= r_hs && (rid == DATA_ID);
    end
  end

  always_ff @(posedge clk) begin
    if (r_hs) rdata_q <= rdata;
  end

  assign inst_data_ok = inst_ok_q;
  assign rd_data_ok   = data_ok_q;
  assign cpu_rdata    = rdata_q;
`else
  assign rready       = (r_state_q == R_R);
  assign r_hs         = rready && rvalid;
  assign r_exit       = r_hs;
  assign inst_data_ok = r_hs && (rid == INST_ID);
  assign rd_data_ok   = r_hs && (rid == DATA_ID);
  assign cpu_rdata    = rdata;
`endif

  assign data_data_ok = rd_data_ok || wr_done;

  wr_channel u_wr_channel (
    .clk       (clk),
    .reset     (reset),
    .start_i   (data_wr_acc),
    .addr_i    (data_addr),
    .wdata_i   (data_wdata),
    .wstrb_i   (data_wstrb),
    .idle_o    (wr_idle),
    .done_o    (wr_done),
    .awaddr_o  (awaddr),
    .awvalid_o (awvalid),
    .awready_i (awready),
    .wdata_o   (wdata),
    .wstrb_o   (wstrb),
    .wvalid_o  (wvalid),
    .wready_i  (wready),
    .bvalid_i  (bvalid),
    .bready_o  (bready)
  );

endmodule
